muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative execution unit for the RV32M multiply/divide group: it consumes the 5-bit operation code from the ALU operation selector (codes 8–15) plus two operands, and returns one XLEN-bit result after a fixed multi-cycle latency. It sits beside the single-cycle ALU datapath. The pipeline control stalls on `busy` and captures `result` on `done`. Signed operands are handled by magnitude conversion, an unsigned shift-add or restoring-divide core, then sign correction.

## Interface
- `XLEN`, default 32: operand and result width; latency scales with it.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `operation`  in  5  operation code: MUL 5'b01000, MULH 5'b01001, MULHU 5'b01010, MULHSU 5'b01011, DIV 5'b01100, DIVU 5'b01101, REM 5'b01110, REMU 5'b01111.
- `op_a`  in  XLEN  rs1 value (dividend / multiplicand).
- `op_b`  in  XLEN  rs2 value (divisor / multiplier).
- `busy`  out  1  operation in progress; new `start` ignored.
- `done`  out  1  one-cycle pulse; `result` valid from this cycle.
- `result`  out  XLEN  result; held until the next accepted `start`.

## Operation
- State machine: IDLE → PREP → CALC (XLEN cycles, counter 0..XLEN-1) → FIX → IDLE. The `done` pulse is emitted on the FIX→IDLE edge.
- Accept: on an edge with `start`=1 and `busy`=0, latch `operation`, `op_a` and `op_b`, then enter PREP. The inputs are don't-care afterwards.
- PREP:
  - Compute operand magnitudes and the result sign.
  - Sign rules:
    - MUL/MULH: both operands signed.
    - MULHSU: `op_a` signed, `op_b` unsigned.
    - MULHU, DIVU, REMU: both unsigned.
    - DIV: result sign is sign(a) XOR sign(b).
    - REM: result sign is sign(a).
  - Flag divide-by-zero (b=0) and signed overflow (DIV/REM with a=-2^(XLEN-1), b=-1).
- CALC, multiply: radix-2 shift-add on a 2·XLEN-bit product, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle. Remainder register is XLEN+1 bits wide.
- FIX:
  - Negate the product/quotient/remainder if the result sign is set.
  - Select MUL = low half; MULH/MULHU/MULHSU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
- Special cases (result forced in FIX; latency unchanged):
  - Divide-by-zero: DIV/DIVU → all ones; REM/REMU → `op_a`.
  - Signed overflow: DIV → 2^(XLEN-1); REM → 0.
- Unsupported code (anything outside 8–15): accepted, runs full latency, `result`=0, `done` still pulses. The handshake never deadlocks.
- `start` while `busy`=1: ignored with no side effects. It is not queued.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- Reset asserted mid-operation: the operation is abandoned immediately (asynchronously). No `done` is issued after release.
- Accept edge E0: `busy`=1 after E0.
- Latency: `done`=1 and `busy`=0 after edge E0+XLEN+2 (E34 for XLEN=32); `done`=0 after the following edge.
- Back-to-back: `start` held high during the `done` cycle is accepted on the next edge (busy=0). Sustained throughput is one op per XLEN+3 cycles.
- `result` updates only on the FIX→IDLE edge. It is stable between done pulses, including while a later operation is busy.

## Test plan
- MUL a=7, b=-3 (0xFFFFFFFD) → result 0xFFFFFFEB. MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. `done` asserted exactly 34 cycles after accept.
- MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF (unsigned) → 0xFFFFFFFF. MULHSU a=2, b=0x80000000 → 0x00000001.
- DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF. REMU 100/7 → 2.
- Corner cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - Each case completes with the normal 34-cycle latency.
- Handshake:
  - Start a DIV, then pulse `start` with new operands at cycle 10: ignored, and the first result is unchanged.
  - Hold `start` through `done`: the second op is accepted on the edge after `done`.
  - Unsupported code 5'b00000: `result`=0 and `done` pulses.
- Reset: drop `rst_n` at cycle 15 of a MUL. Outputs go to 0/IDLE immediately, and no `done` appears after release. A fresh MUL 3×4 after release returns 12.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between pipeline control and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [4:0]      operation;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, operation, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, operation, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: magnitude conversion, XLEN-cycle shift-add or restoring
// divide, then sign correction and special-case selection. Fixed XLEN+3 cycle turnaround.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam int unsigned PW = 2 * XLEN;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_REM    = 5'b01110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic            neg_q, neg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;

    // Operand classification and magnitudes, evaluated while in PREP
    logic            is_valid, is_div, is_rem_sel;
    logic            signed_a, signed_b, a_neg, b_neg, res_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    assign is_valid   = (op_q[4:3] == 2'b01);
    assign is_div     = op_q[2];
    assign is_rem_sel = op_q[1];
    assign signed_a   = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                        (op_q == OP_DIV) || (op_q == OP_REM);
    assign signed_b   = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                        (op_q == OP_DIV) || (op_q == OP_REM);
    assign a_neg      = signed_a & a_q[XLEN-1];
    assign b_neg      = signed_b & b_q[XLEN-1];
    assign mag_a      = a_neg ? -a_q : a_q;
    assign mag_b      = b_neg ? -b_q : b_q;
    assign res_neg    = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);

    // One iteration of each core
    logic [XLEN:0]   mul_sum, div_shift, div_trial;

    assign mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign div_shift = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};

    // Sign correction and result selection for FIX
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

    assign prod_fix = neg_q ? -prod_q : prod_q;
    assign quo_fix  = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        fix_res = '0;
        if (is_valid) begin
            if (!is_div)
                fix_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
            else if (dz_q)
                fix_res = is_rem_sel ? a_q : '1;
            else if (ovf_q)
                fix_res = is_rem_sel ? '0 : MIN_NEG;
            else
                fix_res = is_rem_sel ? rem_fix : quo_fix;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.operation;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_d   = res_neg;
                dz_d    = (b_q == '0);
                ovf_d   = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_NEG) && (b_q == '1);
                opnd_d  = is_div ? mag_b : mag_a;
                prod_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (is_div) begin
                    if (!div_trial[XLEN]) begin
                        rem_d  = div_trial;
                        prod_d = {prod_q[PW-1:XLEN], prod_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d  = div_shift;
                        prod_d = {prod_q[PW-1:XLEN], prod_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    prod_d = {mul_sum, prod_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at accept, compared on done.
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;
    localparam int unsigned LAT  = XLEN + 2;

    localparam logic [4:0] MUL    = 5'b01000;
    localparam logic [4:0] MULH   = 5'b01001;
    localparam logic [4:0] MULHU  = 5'b01010;
    localparam logic [4:0] MULHSU = 5'b01011;
    localparam logic [4:0] DIV    = 5'b01100;
    localparam logic [4:0] DIVU   = 5'b01101;
    localparam logic [4:0] REM    = 5'b01110;
    localparam logic [4:0] REMU   = 5'b01111;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    logic done_prev;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    string       tag_q[$];

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic        [63:0] pu;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ub = {32'b0, b};
        case (op)
            MUL:    begin p = sa * sb; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            REMU: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Result/latency checker driven by the done pulse
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (done_prev)
                check("done_width", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check(tag_q.pop_front(), bus.result, exp_q.pop_front());
                check("latency", 32'(cyc - acc_q.pop_front()), 32'(LAT));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
        done_prev = bus.done;
    end

    task automatic push_exp(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(ref_model(op, a, b));
        acc_q.push_back(cyc);
        tag_q.push_back(tag);
    endtask

    task automatic start_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operation = op;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        push_exp(tag, op, a, b);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.operation = 5'($urandom);
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * LAT; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check("done_low", 32'(bus.done), 32'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(tag, op, a, b);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] rop;
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        done_prev     = 1'b0;
        bus.start     = 1'b0;
        bus.operation = 5'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        rst_n         = 1'b0;
        #1;
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_done",   32'(bus.done), 32'd0);
        check("rst_result", bus.result,    32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7_m3",       MUL,    32'd7,         32'hFFFF_FFFD);
        check("mul_const", bus.result, 32'hFFFF_FFEB);
        run_op("mulh_min_min",   MULH,   32'h8000_0000, 32'h8000_0000);
        check("mulh_const", bus.result, 32'h4000_0000);
        run_op("mulhu_max",      MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu_const", bus.result, 32'hFFFF_FFFE);
        run_op("mulhsu_m1_max",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_2_min",   MULHSU, 32'd2,         32'h8000_0000);
        check("mulhsu_const", bus.result, 32'h0000_0001);
        run_op("div_m7_2",       DIV,    32'hFFFF_FFF9, 32'd2);
        check("div_const", bus.result, 32'hFFFF_FFFD);
        run_op("rem_m7_2",       REM,    32'hFFFF_FFF9, 32'd2);
        check("rem_const", bus.result, 32'hFFFF_FFFF);
        run_op("divu_max_2",     DIVU,   32'hFFFF_FFFF, 32'd2);
        run_op("remu_100_7",     REMU,   32'd100,       32'd7);
        check("remu_const", bus.result, 32'd2);
        run_op("divu_by_zero",   DIVU,   32'd5,         32'd0);
        run_op("rem_by_zero",    REM,    32'd5,         32'd0);
        check("rem_dz_const", bus.result, 32'd5);
        run_op("div_by_zero",    DIV,    32'hFFFF_FFF9, 32'd0);
        run_op("remu_by_zero",   REMU,   32'h1234_5678, 32'd0);
        run_op("div_overflow",   DIV,    32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", bus.result, 32'h8000_0000);
        run_op("rem_overflow",   REM,    32'h8000_0000, 32'hFFFF_FFFF);
        run_op("unsupported_0",  5'b00000, 32'd9,       32'd9);
        run_op("unsupported_21", 5'b10101, 32'hFFFF_FFFF, 32'd3);

        // start pulse while busy must be dropped
        start_op("div_ignored_start", DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (8) @(negedge clk);
        bus.start     = 1'b1;
        bus.operation = MUL;
        bus.op_a      = 32'd11;
        bus.op_b      = 32'd13;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (2 * LAT) @(negedge clk);

        // start held through done is accepted on the following edge
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operation = DIVU;
        bus.op_a      = 32'hFFFF_FFFF;
        bus.op_b      = 32'd2;
        @(posedge clk);
        #1;
        push_exp("b2b_first", DIVU, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 3 * LAT && !bus.done; i++) @(negedge clk);
        check("b2b_done_seen", 32'(bus.done), 32'd1);
        bus.operation = REMU;
        bus.op_a      = 32'd100;
        bus.op_b      = 32'd7;
        @(posedge clk);
        #1;
        push_exp("b2b_second", REMU, 32'd100, 32'd7);
        check("b2b_accept_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("result_held", bus.result, 32'h7FFF_FFFF);
        wait_done();

        // a few random operations across the whole opcode range
        for (int i = 0; i < 16; i++) begin
            rop = 5'(8 + (i % 8));
            run_op("random_op", rop, $urandom, (i % 5 == 4) ? 32'($urandom_range(0, 3)) : $urandom);
        end

        // reset mid-operation abandons the op
        start_op("mul_abandoned", MUL, 32'd5, 32'd6);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(bus.busy), 32'd0);
        check("midrst_done",   32'(bus.done), 32'd0);
        check("midrst_result", bus.result,    32'd0);
        exp_q.delete();
        acc_q.delete();
        tag_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * LAT) @(negedge clk);
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        run_op("mul_3_4", MUL, 32'd3, 32'd4);
        check("mul_3_4_const", bus.result, 32'd12);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
